// File: rtl/sdp_erdma_eg_ro_ctx_unpack_pkg.sv
// Shared definitions for the ERDMA egress read-order context path:
// context field layout, FSM states and lane-mask encodings.
package sdp_erdma_pkg;

   localparam int unsigned CTX_W        = 4;
   localparam int unsigned CTX_CNT_LSB  = 0;
   localparam int unsigned CTX_CNT_W    = 2;
   localparam int unsigned CTX_LAST_BIT = 2;
   localparam int unsigned CTX_HALF_BIT = 3;
   localparam int unsigned MASK_W       = 2;

   localparam logic [MASK_W-1:0] MASK_FULL = 2'b11;
   localparam logic [MASK_W-1:0] MASK_LO   = 2'b01;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } ro_state_e;

   // Only the final beat of a half-width context drops the upper lane
   function automatic logic [MASK_W-1:0] beat_mask(input logic final_beat, input logic half);
      return (final_beat && half) ? MASK_LO : MASK_FULL;
   endfunction

endpackage

// File: rtl/sdp_erdma_eg_ro_ctx_unpack_if.sv
// Handshake bundle for the context unpacker: context FIFO read port,
// DMA response stream and framed egress stream.
interface sdp_erdma_eg_ro_ctx_unpack_if #(
   parameter int unsigned DW = 256
) ();
   import sdp_erdma_pkg::*;

   logic              roc_rd_pvld;
   logic              roc_rd_prdy;
   logic [CTX_W-1:0]  roc_rd_pd;
   logic              dma_rd_rsp_pvld;
   logic              dma_rd_rsp_prdy;
   logic [DW-1:0]     dma_rd_rsp_pd;
   logic              eg_pvld;
   logic              eg_prdy;
   logic [DW-1:0]     eg_data;
   logic [MASK_W-1:0] eg_mask;
   logic              eg_last;
   logic              ctx_done;

   // Environment side: supplies contexts and responses, sinks framed beats
   modport master (
      output roc_rd_pvld, roc_rd_pd, dma_rd_rsp_pvld, dma_rd_rsp_pd, eg_prdy,
      input  roc_rd_prdy, dma_rd_rsp_prdy, eg_pvld, eg_data, eg_mask, eg_last, ctx_done
   );

   // Unpacker side
   modport slave (
      input  roc_rd_pvld, roc_rd_pd, dma_rd_rsp_pvld, dma_rd_rsp_pd, eg_prdy,
      output roc_rd_prdy, dma_rd_rsp_prdy, eg_pvld, eg_data, eg_mask, eg_last, ctx_done
   );

endinterface

// File: rtl/sdp_erdma_eg_ro_ctx_unpack_pipe_reg.sv
// Single-stage valid/ready register; accepts a new word in the same cycle
// the held word drains, so it sustains one transfer per cycle.
module sdp_erdma_pipe_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_data,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_data
);

   assign in_rdy = !out_vld || out_rdy;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_vld  <= 1'b0;
         out_data <= '0;
      end else if (in_vld && in_rdy) begin
         out_vld  <= 1'b1;
         out_data <= in_data;
      end else if (out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

endmodule

// File: rtl/sdp_erdma_eg_ro_ctx_unpack.sv
// Pops one read-order context per DMA read and frames the matching response
// beats with lane mask, end-of-surface flag and a per-context done pulse.
module sdp_erdma_eg_ro_ctx_unpack
   import sdp_erdma_pkg::*;
#(
   parameter int unsigned DW = 256
) (
   input logic                    nvdla_core_clk,
   input logic                    nvdla_core_rst,
   sdp_erdma_eg_ro_ctx_unpack_if.slave bus
);

   localparam int unsigned PW = DW + MASK_W + 1;

   ro_state_e            state;
   logic [CTX_CNT_W-1:0] beat_rem;
   logic                 last_f;
   logic                 half_f;
   logic                 ctx_done_q;

   logic                 out_free;
   logic                 rsp_acc;
   logic                 final_beat;
   logic                 ctx_pop;
   logic                 roc_rd_prdy_c;
   logic                 pipe_vld;
   logic [PW-1:0]        pipe_in;
   logic [PW-1:0]        pipe_out;

   // Handshakes: context pop from IDLE or on the final-beat accept, so the
   // next context loads with no bubble between contexts
   always_comb begin
      rsp_acc       = (state == BUSY) && bus.dma_rd_rsp_pvld && out_free;
      final_beat    = rsp_acc && (beat_rem == '0);
      roc_rd_prdy_c = (state == IDLE) || final_beat;
      ctx_pop       = bus.roc_rd_pvld && roc_rd_prdy_c;
      pipe_in       = {bus.dma_rd_rsp_pd, beat_mask(final_beat, half_f), final_beat && last_f};
   end

   assign bus.roc_rd_prdy     = roc_rd_prdy_c;
   assign bus.dma_rd_rsp_prdy = (state == BUSY) && out_free;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         state      <= IDLE;
         beat_rem   <= '0;
         last_f     <= 1'b0;
         half_f     <= 1'b0;
         ctx_done_q <= 1'b0;
      end else begin
         ctx_done_q <= final_beat;
         if (ctx_pop) begin
            state    <= BUSY;
            beat_rem <= bus.roc_rd_pd[CTX_CNT_LSB +: CTX_CNT_W];
            last_f   <= bus.roc_rd_pd[CTX_LAST_BIT];
            half_f   <= bus.roc_rd_pd[CTX_HALF_BIT];
         end else if (final_beat) begin
            state    <= IDLE;
         end else if (rsp_acc) begin
            beat_rem <= beat_rem - CTX_CNT_W'(1);
         end
      end
   end

   sdp_erdma_pipe_reg #(
      .W (PW)
   ) u_out_reg (
      .clk      (nvdla_core_clk),
      .rst      (nvdla_core_rst),
      .in_vld   (rsp_acc),
      .in_rdy   (out_free),
      .in_data  (pipe_in),
      .out_vld  (pipe_vld),
      .out_rdy  (bus.eg_prdy),
      .out_data (pipe_out)
   );

   assign bus.eg_pvld  = pipe_vld;
   assign bus.eg_data  = pipe_out[PW-1 -: DW];
   assign bus.eg_mask  = pipe_out[MASK_W:1];
   assign bus.eg_last  = pipe_out[0];
   assign bus.ctx_done = ctx_done_q;

endmodule

// File: tb/tb_sdp_erdma_eg_ro_ctx_unpack.sv
// Scoreboard bench for the context unpacker: expected framed beats are
// queued as contexts/responses are scheduled and compared at egress.
module tb_sdp_erdma_eg_ro_ctx_unpack;

   localparam int unsigned DW = 256;
   localparam int unsigned CW = DW + 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdp_erdma_eg_ro_ctx_unpack_if #(.DW(DW)) bus ();

   sdp_erdma_eg_ro_ctx_unpack #(.DW(DW)) u_dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rst (rst),
      .bus            (bus)
   );

   logic [3:0]    ctx_q[$];
   logic [DW-1:0] dat_q[$];
   logic [CW-1:0] exp_q[$];
   int            out_cyc_q[$];
   logic          rprdy_q[$];
   int            n_chk  = 0;
   int            n_pass = 0;
   int            done_cnt = 0;

   task automatic check_eq(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   // Schedule one context plus its response beats and the expected framing
   task automatic push_ctx(input logic [3:0] pd);
      int            n;
      logic [DW-1:0] d;
      logic          fin;
      logic [1:0]    m;
      n = int'(pd[1:0]) + 1;
      for (int i = 0; i < n; i++) begin
         d   = rand_data();
         fin = (i == n - 1);
         m   = (fin && pd[3]) ? 2'b01 : 2'b11;
         dat_q.push_back(d);
         exp_q.push_back({d, m, fin && pd[2]});
      end
      ctx_q.push_back(pd);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && dat_q.size() == 0 && ctx_q.size() == 0) break;
      end
      check_eq(tag, CW'(exp_q.size()), CW'(0));
      repeat (2) @(negedge clk);
   endtask

   // Upstream driver: holds each head item until its handshake completes
   initial begin
      logic rfire, dfire;
      bus.roc_rd_pvld     = 1'b0;
      bus.roc_rd_pd       = '0;
      bus.dma_rd_rsp_pvld = 1'b0;
      bus.dma_rd_rsp_pd   = '0;
      forever begin
         @(negedge clk);
         rfire = bus.roc_rd_pvld && bus.roc_rd_prdy && !rst;
         dfire = bus.dma_rd_rsp_pvld && bus.dma_rd_rsp_prdy && !rst;
         if (dfire) rprdy_q.push_back(bus.roc_rd_prdy);
         @(posedge clk);
         #1;
         if (rfire && ctx_q.size() > 0) void'(ctx_q.pop_front());
         if (dfire && dat_q.size() > 0) void'(dat_q.pop_front());
         bus.roc_rd_pvld     = (ctx_q.size() > 0);
         bus.roc_rd_pd       = (ctx_q.size() > 0) ? ctx_q[0] : 4'h0;
         bus.dma_rd_rsp_pvld = (dat_q.size() > 0);
         bus.dma_rd_rsp_pd   = (dat_q.size() > 0) ? dat_q[0] : '0;
      end
   end

   // Egress monitor: scoreboard compare, done alignment, hold under stall
   initial begin
      logic [CW-1:0] got, want, prev_got;
      logic          hold_prev;
      hold_prev = 1'b0;
      prev_got  = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            hold_prev = 1'b0;
         end else begin
            got = {bus.eg_data, bus.eg_mask, bus.eg_last};
            if (bus.eg_pvld && bus.eg_prdy) begin
               want = 'x;
               if (exp_q.size() > 0) want = exp_q.pop_front();
               check_eq("eg_beat", got, want);
               out_cyc_q.push_back(cyc);
            end
            if (bus.ctx_done) begin
               done_cnt++;
               check_eq("done_align", CW'(bus.eg_pvld), CW'(1));
            end
            if (hold_prev) check_eq("eg_hold", got, prev_got);
            hold_prev = bus.eg_pvld && !bus.eg_prdy;
            prev_got  = got;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int            b, rb, d0;
      logic          seen;
      logic [DW-1:0] d;
      bus.eg_prdy = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_eg_pvld",   CW'(bus.eg_pvld),         CW'(0));
      check_eq("rst_eg_mask",   CW'(bus.eg_mask),         CW'(0));
      check_eq("rst_eg_last",   CW'(bus.eg_last),         CW'(0));
      check_eq("rst_eg_data",   CW'(bus.eg_data),         CW'(0));
      check_eq("rst_ctx_done",  CW'(bus.ctx_done),        CW'(0));
      check_eq("rst_roc_prdy",  CW'(bus.roc_rd_prdy),     CW'(1));
      check_eq("rst_rsp_prdy",  CW'(bus.dma_rd_rsp_prdy), CW'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Single two-beat surface-last context
      b  = out_cyc_q.size();
      d0 = done_cnt;
      push_ctx(4'b0101);
      wait_drain("t1_drain");
      check_eq("t1_gap",  CW'(out_cyc_q[b+1] - out_cyc_q[b]), CW'(1));
      check_eq("t1_done", CW'(done_cnt - d0), CW'(1));

      // Back-to-back 4-beat then 1-beat contexts
      b  = out_cyc_q.size();
      rb = rprdy_q.size();
      push_ctx(4'h3);
      push_ctx(4'h0);
      wait_drain("t2_drain");
      check_eq("t2_span",      CW'(out_cyc_q[b+4] - out_cyc_q[b]), CW'(4));
      check_eq("t2_pop_beat3", CW'(rprdy_q[rb+2]), CW'(0));
      check_eq("t2_pop_beat4", CW'(rprdy_q[rb+3]), CW'(1));

      // Half-width final beat
      push_ctx(4'b1001);
      wait_drain("t3_drain");

      // Backpressure for 3 cycles mid-context
      push_ctx(4'h3);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.eg_pvld) break;
      end
      @(posedge clk);
      #1 bus.eg_prdy = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check_eq("t4_rsp_stall", CW'(bus.dma_rd_rsp_prdy), CW'(0));
      end
      @(posedge clk);
      #1 bus.eg_prdy = 1'b1;
      wait_drain("t4_drain");

      // Response data waiting with no context loaded
      d = rand_data();
      dat_q.push_back(d);
      exp_q.push_back({d, 2'b11, 1'b0});
      repeat (3) begin
         @(negedge clk);
         check_eq("t5_no_ctx", CW'(bus.dma_rd_rsp_prdy), CW'(0));
      end
      ctx_q.push_back(4'h0);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.roc_rd_pvld && bus.roc_rd_prdy) begin
            seen = 1'b1;
            check_eq("t5_pop_cycle", CW'(bus.dma_rd_rsp_prdy), CW'(0));
            @(negedge clk);
            check_eq("t5_after_pop", CW'(bus.dma_rd_rsp_prdy), CW'(1));
            break;
         end
      end
      check_eq("t5_pop_seen", CW'(seen), CW'(1));
      wait_drain("t5_drain");

      // Reset after the first beat of a 4-beat context
      bus.eg_prdy = 1'b0;
      d = rand_data();
      ctx_q.push_back(4'h3);
      dat_q.push_back(d);
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (bus.eg_pvld) break;
      end
      check_eq("t6_pre_data", CW'(bus.eg_data), CW'(d));
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check_eq("t6_eg_pvld",   CW'(bus.eg_pvld),         CW'(0));
      check_eq("t6_eg_data",   CW'(bus.eg_data),         CW'(0));
      check_eq("t6_eg_mask",   CW'(bus.eg_mask),         CW'(0));
      check_eq("t6_eg_last",   CW'(bus.eg_last),         CW'(0));
      check_eq("t6_rsp_prdy",  CW'(bus.dma_rd_rsp_prdy), CW'(0));
      check_eq("t6_roc_prdy",  CW'(bus.roc_rd_prdy),     CW'(1));
      @(posedge clk);
      #1 rst = 1'b0;
      bus.eg_prdy = 1'b1;
      push_ctx(4'h4);
      wait_drain("t6_drain");

      check_eq("done_total", CW'(done_cnt), CW'(7));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sdp_erdma_eg_ro_ctx_unpack.md
# sdp_erdma_eg_ro_ctx_unpack

Read-side consumer of the SDP ERDMA egress read-order context FIFO. It pops one 4-bit context per DMA read request and uses it to frame the matching DMA response beats. Each framed beat leaves with a lane mask and an end-of-surface flag. The block sits between the cfifo read port and the ERDMA egress data path, and provides one registered output stage with full-throughput valid/ready.

## Interface
Parameters:
- DW, 256, DMA response data width in bits; must be even (two DW/2 lanes).

Ports:
- nvdla_core_clk  in  1  core clock; all state on its rising edge.
- nvdla_core_rst  in  1  reset; asynchronous, active-high; one clock, no other reset.
- roc_rd_pvld  in  1  context valid, from the context FIFO.
- roc_rd_prdy  out  1  context pop.
- roc_rd_pd  in  4  context word:
  - [1:0] = beat count minus 1
  - [2] = last context of surface
  - [3] = final beat is half-width
- dma_rd_rsp_pvld  in  1  response beat valid.
- dma_rd_rsp_prdy  out  1  response beat accept.
- dma_rd_rsp_pd  in  DW  response data.
- eg_pvld  out  1  framed beat valid.
- eg_prdy  in  1  downstream ready.
- eg_data  out  DW  framed data.
- eg_mask  out  2  lane mask: bit0 = lower DW/2, bit1 = upper DW/2.
- eg_last  out  1  final beat of a context whose pd[2] = 1.
- ctx_done  out  1  single-cycle pulse when the final beat of any context is accepted into the output stage.

## Operation
State machine:
- IDLE: no context loaded. roc_rd_prdy = 1 and dma_rd_rsp_prdy = 0.
  - IDLE -> BUSY on a context pop; load beat_rem = pd[1:0], last_f = pd[2], half_f = pd[3].
- BUSY: dma_rd_rsp_prdy = out_free, where out_free = !eg_pvld | eg_prdy.
  - Each accepted beat: beat_rem decrements (2-bit, no wrap is possible because the final beat exits).
  - Final beat = accepted beat with beat_rem == 0.

Back-to-back contexts:
- In BUSY, roc_rd_prdy = final-beat accept.
- If roc_rd_pvld is high in that same cycle, the next context loads and the FSM stays in BUSY with no bubble.
- Otherwise the FSM goes to IDLE.

Response beats with no loaded context are held through backpressure; none are dropped.

Output stage: one register, loaded on beat accept.
- eg_mask = 2'b01 when final beat && half_f; otherwise 2'b11.
- eg_last = final beat && last_f.
- eg_pvld clears when eg_prdy is high and no new beat is loaded.

roc_rd_pd[1:0] = 3 means 4 beats; contexts carry 1..4 beats.

## Timing
- Reset values: eg_pvld = 0, eg_mask = 2'b00, eg_last = 0, eg_data = 0, ctx_done = 0, state = IDLE, beat_rem = 0. roc_rd_prdy = 1 during and after reset; dma_rd_rsp_prdy = 0.
- Reset asserted mid-context: the loaded context and the output register are discarded. Upstream must be reset together with this block.
- Latency: response beat accepted at cycle N -> eg_pvld with that data at N+1.
- Throughput: 1 beat/cycle while eg_prdy is held high, including across context boundaries.
- Context pop to first data accept: 1 cycle minimum, because the context registers before dma_rd_rsp_prdy rises from IDLE.
- Handshake rule: eg_data, eg_mask and eg_last hold stable while eg_pvld && !eg_prdy.
- ctx_done is asserted in the cycle after the final-beat accept, aligned with that beat's eg_pvld.

## Structure
- Shared package sdp_erdma_pkg holds:
  - ctx field offsets (CTX_CNT_LSB = 0, CTX_CNT_W = 2, CTX_LAST_BIT = 2, CTX_HALF_BIT = 3)
  - the FSM state enum (IDLE, BUSY)
  - mask constants MASK_FULL = 2'b11, MASK_LO = 2'b01
- One sub-module: sdp_erdma_pipe_reg, a single-stage valid/ready register parameterised on width. It is instantiated once for {eg_data, eg_mask, eg_last}.
- The FSM and beat counter stay in the top module.

## Test plan
- Single context: pd = 4'b0101 (2 beats, last) with beats D0, D1 and eg_prdy = 1. Required: eg outputs D0 then D1 on consecutive cycles, mask 11 on both, eg_last on D1 only, ctx_done once.
- Back-to-back contexts: pd = 4'h3 (4 beats), then 4'h0 (1 beat), data streaming continuously. Required: 5 consecutive eg_pvld cycles with no bubble, and roc_rd_prdy high on beat 4.
- Half-width final beat: pd = 4'b1001. Required: beat0 mask 11, beat1 mask 01, eg_last = 0.
- Backpressure: eg_prdy held at 0 for 3 cycles mid-context. Required: eg_data is stable, dma_rd_rsp_prdy = 0, no beat is lost, and the count resumes correctly.
- Data before context: dma_rd_rsp_pvld asserted with roc_rd_pvld = 0. Required: dma_rd_rsp_prdy = 0 until 1 cycle after the context pop.
- Reset mid-context: assert nvdla_core_rst after beat 1 of a 4-beat context. Required: outputs return to their reset values asynchronously, state = IDLE, and a subsequent fresh 1-beat context frames correctly.
